// File: rtl/cfu_cmd_sequencer.sv
// CFU command sequencer: buffers upstream commands, issues them to a CFU
// under response-buffer credit, and returns results in order downstream.
module cfu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [9:0]  s_function_id,
    input  logic [31:0] s_inputs_0,
    input  logic [31:0] s_inputs_1,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        busy,
    output logic [15:0] issued_count,
    output logic [15:0] completed_count,
    output logic        proto_err
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);

    logic [9:0]   cmd_fid_q [CMD_DEPTH];
    logic [31:0]  cmd_in0_q [CMD_DEPTH];
    logic [31:0]  cmd_in1_q [CMD_DEPTH];
    logic [9:0]   cmd_fid_d [CMD_DEPTH];
    logic [31:0]  cmd_in0_d [CMD_DEPTH];
    logic [31:0]  cmd_in1_d [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;

    logic [31:0]  rsp_mem_q [RSP_DEPTH];
    logic [31:0]  rsp_mem_d [RSP_DEPTH];
    logic [RAW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [RAW:0]   rsp_cnt_q, rsp_cnt_d;

    logic [RAW:0]   outstanding_q, outstanding_d;
    logic [15:0]    issued_q, issued_d, completed_q, completed_d;
    logic           proto_err_q, proto_err_d;

    logic           cmd_empty, cmd_full, rsp_empty, has_credit;
    logic           cmd_push, cmd_fire, rsp_fire, rsp_pop;
    logic [RAW+1:0] credit_used;

    // Handshake decode; cmd_valid depends only on registered state so a
    // combinational CFU cannot close a loop through cmd_ready/rsp_valid.
    always_comb begin
        cmd_empty   = (cmd_cnt_q == '0);
        cmd_full    = (cmd_cnt_q == (CAW+1)'(CMD_DEPTH));
        rsp_empty   = (rsp_cnt_q == '0);
        credit_used = {1'b0, outstanding_q} + {1'b0, rsp_cnt_q};
        has_credit  = (credit_used < (RAW+2)'(RSP_DEPTH));
        s_ready     = !cmd_full;
        cmd_valid   = !cmd_empty && has_credit;
        rsp_ready   = (outstanding_q != '0) || cmd_valid;
        m_valid     = !rsp_empty;
        cmd_push    = s_valid && s_ready;
        cmd_fire    = cmd_valid && cmd_ready;
        rsp_fire    = rsp_valid && rsp_ready;
        rsp_pop     = m_valid && m_ready;
        busy        = !cmd_empty || (outstanding_q != '0) || !rsp_empty;
        cmd_payload_function_id = cmd_fid_q[cmd_rd_q];
        cmd_payload_inputs_0    = cmd_in0_q[cmd_rd_q];
        cmd_payload_inputs_1    = cmd_in1_q[cmd_rd_q];
        m_data          = rsp_mem_q[rsp_rd_q];
        issued_count    = issued_q;
        completed_count = completed_q;
        proto_err       = proto_err_q;
    end

    // Next-state for both FIFOs, the in-flight counter and the statistics.
    always_comb begin
        cmd_fid_d     = cmd_fid_q;
        cmd_in0_d     = cmd_in0_q;
        cmd_in1_d     = cmd_in1_q;
        cmd_wr_d      = cmd_wr_q;
        cmd_rd_d      = cmd_rd_q;
        cmd_cnt_d     = cmd_cnt_q;
        rsp_mem_d     = rsp_mem_q;
        rsp_wr_d      = rsp_wr_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_cnt_d     = rsp_cnt_q;
        outstanding_d = outstanding_q;
        issued_d      = issued_q;
        completed_d   = completed_q;
        proto_err_d   = proto_err_q;

        if (cmd_push) begin
            cmd_fid_d[cmd_wr_q] = s_function_id;
            cmd_in0_d[cmd_wr_q] = s_inputs_0;
            cmd_in1_d[cmd_wr_q] = s_inputs_1;
            cmd_wr_d            = cmd_wr_q + CAW'(1);
        end
        if (cmd_fire) begin
            cmd_rd_d = cmd_rd_q + CAW'(1);
            issued_d = issued_q + 16'd1;
        end
        case ({cmd_push, cmd_fire})
            2'b10:   cmd_cnt_d = cmd_cnt_q + (CAW+1)'(1);
            2'b01:   cmd_cnt_d = cmd_cnt_q - (CAW+1)'(1);
            default: cmd_cnt_d = cmd_cnt_q;
        endcase

        if (rsp_fire) begin
            rsp_mem_d[rsp_wr_q] = rsp_payload_outputs_0;
            rsp_wr_d            = rsp_wr_q + RAW'(1);
            completed_d         = completed_q + 16'd1;
        end
        if (rsp_pop) begin
            rsp_rd_d = rsp_rd_q + RAW'(1);
        end
        case ({rsp_fire, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + (RAW+1)'(1);
            2'b01:   rsp_cnt_d = rsp_cnt_q - (RAW+1)'(1);
            default: rsp_cnt_d = rsp_cnt_q;
        endcase

        case ({cmd_fire, rsp_fire})
            2'b10:   outstanding_d = outstanding_q + (RAW+1)'(1);
            2'b01:   outstanding_d = outstanding_q - (RAW+1)'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // A response with nothing issued and nothing issuable is unsolicited.
        if (rsp_valid && (outstanding_q == '0) && !cmd_valid) begin
            proto_err_d = 1'b1;
        end
    end

    // State registers; storage is cleared so payload outputs read zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cmd_fid_q[i] <= '0;
                cmd_in0_q[i] <= '0;
                cmd_in1_q[i] <= '0;
            end
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem_q[i] <= '0;
            end
            cmd_wr_q      <= '0;
            cmd_rd_q      <= '0;
            cmd_cnt_q     <= '0;
            rsp_wr_q      <= '0;
            rsp_rd_q      <= '0;
            rsp_cnt_q     <= '0;
            outstanding_q <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            cmd_fid_q     <= cmd_fid_d;
            cmd_in0_q     <= cmd_in0_d;
            cmd_in1_q     <= cmd_in1_d;
            rsp_mem_q     <= rsp_mem_d;
            cmd_wr_q      <= cmd_wr_d;
            cmd_rd_q      <= cmd_rd_d;
            cmd_cnt_q     <= cmd_cnt_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_cnt_q     <= rsp_cnt_d;
            outstanding_q <= outstanding_d;
            issued_q      <= issued_d;
            completed_q   <= completed_d;
            proto_err_q   <= proto_err_d;
        end
    end
endmodule
